// File: rtl/banked_data_memory.sv
// Two-bank (scratch + main) word memory behind a valid/ready request port, with a
// fixed-latency read pipeline feeding a credit-limited response FIFO.
module banked_data_memory #(
  parameter int    DATA_W     = 32,
  parameter int    ADDR_W     = 32,
  parameter int    SPLIT_ADDR = 256,
  parameter int    LOW_DEPTH  = 64,
  parameter int    HIGH_DEPTH = 4096,
  parameter int    READ_LAT   = 2,
  parameter string INIT_FILE  = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wd,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rd,
  output logic                resp_err
);
  localparam int BE_W       = DATA_W / 8;
  localparam int OFF        = $clog2(BE_W);
  localparam int RESP_DEPTH = READ_LAT + 1;
  localparam int CNT_W      = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W      = $clog2(RESP_DEPTH);
  localparam int PIPE_N     = (READ_LAT > 1) ? READ_LAT - 1 : 1;
  localparam int LOW_AW     = (LOW_DEPTH > 1) ? $clog2(LOW_DEPTH) : 1;
  localparam int HIGH_AW    = (HIGH_DEPTH > 1) ? $clog2(HIGH_DEPTH) : 1;
  // The FIFO entry register is the final latency stage, so READ_LAT=1 writes it straight from the bank.
  localparam bit DIRECT     = (READ_LAT == 1);

  logic [DATA_W-1:0] low_mem  [LOW_DEPTH];
  logic [DATA_W-1:0] high_mem [HIGH_DEPTH];

  logic              is_low, addr_err, accept, pop;
  logic [ADDR_W-1:0] low_word, main_word;
  logic [DATA_W-1:0] bank_word, acc_rd;
  logic              push_v, push_err;
  logic [DATA_W-1:0] push_rd;

  logic              pipe_v_q   [PIPE_N];
  logic              pipe_v_d   [PIPE_N];
  logic [DATA_W-1:0] pipe_rd_q  [PIPE_N];
  logic [DATA_W-1:0] pipe_rd_d  [PIPE_N];
  logic              pipe_err_q [PIPE_N];
  logic              pipe_err_d [PIPE_N];
  logic [DATA_W-1:0] fifo_rd_q  [RESP_DEPTH];
  logic [DATA_W-1:0] fifo_rd_d  [RESP_DEPTH];
  logic              fifo_err_q [RESP_DEPTH];
  logic              fifo_err_d [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d, inflight_q, inflight_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RESP_DEPTH - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = p + PTR_W'(1);
    end
  endfunction

  assign req_ready  = !rst && ((inflight_q + count_q) < CNT_W'(RESP_DEPTH));
  assign resp_valid = (count_q != '0);
  assign resp_rd    = resp_valid ? fifo_rd_q[rd_ptr_q] : '0;
  assign resp_err   = resp_valid ? fifo_err_q[rd_ptr_q] : 1'b0;

  // Address decode, error detection and bank read for the request being accepted.
  always_comb begin
    is_low    = (req_addr < ADDR_W'(SPLIT_ADDR));
    low_word  = req_addr >> OFF;
    main_word = (req_addr - ADDR_W'(SPLIT_ADDR)) >> OFF;
    if (is_low) begin
      addr_err  = (|req_addr[OFF-1:0]) || (low_word >= ADDR_W'(LOW_DEPTH));
      bank_word = low_mem[low_word[LOW_AW-1:0]];
    end else begin
      addr_err  = (|req_addr[OFF-1:0]) || (main_word >= ADDR_W'(HIGH_DEPTH));
      bank_word = high_mem[main_word[HIGH_AW-1:0]];
    end
    accept = req_valid && req_ready;
    acc_rd = (accept && !req_we && !addr_err) ? bank_word : '0;
  end

  // Byte-enabled store commit at the acceptance edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !addr_err) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_be[b]) begin
          if (is_low) begin
            low_mem[low_word[LOW_AW-1:0]][b*8 +: 8] <= req_wd[b*8 +: 8];
          end else begin
            high_mem[main_word[HIGH_AW-1:0]][b*8 +: 8] <= req_wd[b*8 +: 8];
          end
        end
      end
    end
  end

  // Next-state for the latency pipeline, response FIFO and credit counters.
  always_comb begin
    pipe_v_d      = pipe_v_q;
    pipe_rd_d     = pipe_rd_q;
    pipe_err_d    = pipe_err_q;
    pipe_v_d[0]   = DIRECT ? 1'b0 : accept;
    pipe_rd_d[0]  = acc_rd;
    pipe_err_d[0] = addr_err;
    for (int k = 1; k < PIPE_N; k++) begin
      pipe_v_d[k]   = pipe_v_q[k-1];
      pipe_rd_d[k]  = pipe_rd_q[k-1];
      pipe_err_d[k] = pipe_err_q[k-1];
    end
    inflight_d = '0;
    for (int k = 0; k < PIPE_N; k++) begin
      if (pipe_v_d[k]) begin
        inflight_d = inflight_d + CNT_W'(1);
      end else begin
        inflight_d = inflight_d;
      end
    end

    push_v   = DIRECT ? accept   : pipe_v_q[PIPE_N-1];
    push_rd  = DIRECT ? acc_rd   : pipe_rd_q[PIPE_N-1];
    push_err = DIRECT ? addr_err : pipe_err_q[PIPE_N-1];
    pop      = resp_valid && resp_ready;

    fifo_rd_d  = fifo_rd_q;
    fifo_err_d = fifo_err_q;
    if (push_v) begin
      fifo_rd_d[wr_ptr_q]  = push_rd;
      fifo_err_d[wr_ptr_q] = push_err;
      wr_ptr_d             = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_v && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_v && pop) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // State registers; reset drops every in-flight and buffered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_N; k++) begin
        pipe_v_q[k]   <= 1'b0;
        pipe_rd_q[k]  <= '0;
        pipe_err_q[k] <= 1'b0;
      end
      for (int k = 0; k < RESP_DEPTH; k++) begin
        fifo_rd_q[k]  <= '0;
        fifo_err_q[k] <= 1'b0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      pipe_v_q   <= pipe_v_d;
      pipe_rd_q  <= pipe_rd_d;
      pipe_err_q <= pipe_err_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_err_q <= fifo_err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end
endmodule
